// File: rtl/conv_window_ctrl_pkg.sv
// Shared types and helpers for the convolution line-buffer window sequencer.
package conv_window_ctrl_pkg;

  // Row/column counter width; image dimensions must stay below 2**CNT_W.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic pos_before(
    input logic [CNT_W-1:0] a_row,
    input logic [CNT_W-1:0] a_col,
    input logic [CNT_W-1:0] b_row,
    input logic [CNT_W-1:0] b_col
  );
    return (a_row < b_row) || ((a_row == b_row) && (a_col < b_col));
  endfunction

endpackage

// File: rtl/conv_window_ctrl_addr_gen.sv
// Combinational K*K read-address generator: slot row of the window top plus
// window column -> packed per-port bram addresses, port index ky*K+kx.
module conv_win_addr_gen
  import conv_window_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int IMG_WIDTH   = 7,
  parameter int KERNEL_SIZE = 3,
  parameter int RAM_PORTS   = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic [CNT_W-1:0]                slot_row,
  input  logic [CNT_W-1:0]                col,
  output logic [ADDR_WIDTH*RAM_PORTS-1:0] r_addrs
);

  int row_s;
  int addr_s;

  // Slot rows wrap modulo K with a single conditional subtract since slot_row < K.
  always_comb begin
    r_addrs = '0;
    row_s   = 0;
    addr_s  = 0;
    for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
      for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
        row_s  = int'(slot_row) + ky;
        row_s  = (row_s >= KERNEL_SIZE) ? (row_s - KERNEL_SIZE) : row_s;
        addr_s = row_s * IMG_WIDTH + int'(col) + kx;
        r_addrs[(ky*KERNEL_SIZE+kx)*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(addr_s);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer window sequencer: streams pixels into a K-row circular bram and
// issues every K*K window read in one cycle, with valid/ready on both sides.
module conv_window_ctrl
  import conv_window_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int RAM_WIDTH   = 8,
  parameter int IMG_WIDTH   = 7,
  parameter int IMG_HEIGHT  = 7,
  parameter int KERNEL_SIZE = 3,
  parameter int RAM_DEPTH   = KERNEL_SIZE * IMG_WIDTH,
  parameter int RAM_PORTS   = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic                            i_start,
  input  logic                            i_pix_valid,
  input  logic [RAM_WIDTH-1:0]            i_pix_data,
  output logic                            o_pix_ready,
  output logic                            o_wr_en,
  output logic [ADDR_WIDTH-1:0]           o_w_addr,
  output logic [RAM_WIDTH-1:0]            o_wr_data,
  output logic [ADDR_WIDTH*RAM_PORTS-1:0] o_r_addrs,
  output logic                            o_win_valid,
  input  logic                            i_win_ready,
  output logic                            o_busy,
  output logic                            o_frame_done
);

  localparam logic [CNT_W-1:0]      K_C       = CNT_W'(KERNEL_SIZE);
  localparam logic [CNT_W-1:0]      K_LAST    = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0]      H_C       = CNT_W'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0]      W_LAST    = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0]      WIN_ROWS  = CNT_W'(IMG_HEIGHT - KERNEL_SIZE + 1);
  localparam logic [CNT_W-1:0]      WR_LAST   = CNT_W'(IMG_HEIGHT - KERNEL_SIZE);
  localparam logic [CNT_W-1:0]      WC_LAST   = CNT_W'(IMG_WIDTH - KERNEL_SIZE);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] WPTR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] WPTR_ONE  = ADDR_WIDTH'(1);

  state_t                          state_r, state_next_s;
  logic [CNT_W-1:0]                prow_r, pcol_r;
  logic [CNT_W-1:0]                wrow_r, wcol_r, srow_r;
  logic [CNT_W-1:0]                hrow_r, hcol_r;
  logic [ADDR_WIDTH-1:0]           wptr_r;
  logic                            win_valid_r, frame_done_r;
  logic [ADDR_WIDTH*RAM_PORTS-1:0] hold_r, gen_addrs_s;
  logic [CNT_W-1:0]                guard_row_s, guard_col_s;
  logic                            guard_ok_s, pix_ready_s, pix_acc_s;
  logic                            issuable_s, advance_s, win_hs_s, last_hs_s, frame_start_s;

  conv_win_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .KERNEL_SIZE(KERNEL_SIZE),
    .RAM_PORTS  (RAM_PORTS)
  ) u_addr_gen (
    .slot_row(srow_r),
    .col     (wcol_r),
    .r_addrs (gen_addrs_s)
  );

  // Overwrite guard: the slot about to be written must no longer be needed by any
  // window still waiting for its handshake (hrow/hcol = next window to handshake).
  always_comb begin
    guard_row_s = '0;
    guard_col_s = '0;
    if (prow_r >= K_C) begin
      guard_row_s = prow_r - K_C;
      guard_col_s = (pcol_r > WC_LAST) ? WC_LAST : pcol_r;
      guard_ok_s  = pos_before(guard_row_s, guard_col_s, hrow_r, hcol_r);
    end else begin
      guard_ok_s  = 1'b1;
    end
  end

  assign frame_start_s = (state_r == ST_IDLE) && i_start;
  assign pix_ready_s   = (state_r == ST_RUN) && (prow_r != H_C) && guard_ok_s;
  assign pix_acc_s     = i_pix_valid && pix_ready_s;
  assign issuable_s    = (state_r == ST_RUN) && (wrow_r != WIN_ROWS) &&
                         pos_before(wrow_r + K_LAST, wcol_r + K_LAST, prow_r, pcol_r);
  assign win_hs_s      = win_valid_r && i_win_ready;
  assign advance_s     = issuable_s && (!win_valid_r || i_win_ready);
  assign last_hs_s     = win_hs_s && (hrow_r == WR_LAST) && (hcol_r == WC_LAST);

  // FSM state register and registered frame-done pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r      <= ST_IDLE;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      frame_done_r <= (state_next_s == ST_DONE);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = i_start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next_s = last_hs_s ? ST_DONE : ST_RUN;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs; while a window is stalled the hold copy keeps the bram re-reading it.
  always_comb begin
    o_busy      = (state_r != ST_IDLE);
    o_pix_ready = pix_ready_s;
    o_wr_en     = pix_acc_s;
    o_w_addr    = wptr_r;
    o_wr_data   = i_pix_data;
    if (win_valid_r && !i_win_ready) begin
      o_r_addrs = hold_r;
    end else begin
      o_r_addrs = gen_addrs_s;
    end
  end

  assign o_win_valid  = win_valid_r;
  assign o_frame_done = frame_done_r;

  // Pixel raster counters and circular write pointer.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prow_r <= '0;
      pcol_r <= '0;
      wptr_r <= '0;
    end else if (frame_start_s) begin
      prow_r <= '0;
      pcol_r <= '0;
      wptr_r <= '0;
    end else if (pix_acc_s) begin
      wptr_r <= (wptr_r == WPTR_LAST) ? '0 : (wptr_r + WPTR_ONE);
      if (pcol_r == W_LAST) begin
        pcol_r <= '0;
        prow_r <= prow_r + CNT_ONE;
      end else begin
        pcol_r <= pcol_r + CNT_ONE;
      end
    end
  end

  // Window issue/handshake counters, slot row, valid flag and address hold copy.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wrow_r      <= '0;
      wcol_r      <= '0;
      srow_r      <= '0;
      hrow_r      <= '0;
      hcol_r      <= '0;
      win_valid_r <= 1'b0;
      hold_r      <= '0;
    end else if (frame_start_s) begin
      wrow_r      <= '0;
      wcol_r      <= '0;
      srow_r      <= '0;
      hrow_r      <= '0;
      hcol_r      <= '0;
      win_valid_r <= 1'b0;
    end else begin
      if (advance_s) begin
        win_valid_r <= 1'b1;
        hold_r      <= gen_addrs_s;
        if (wcol_r == WC_LAST) begin
          wcol_r <= '0;
          wrow_r <= wrow_r + CNT_ONE;
          srow_r <= (srow_r == K_LAST) ? '0 : (srow_r + CNT_ONE);
        end else begin
          wcol_r <= wcol_r + CNT_ONE;
        end
      end else if (win_hs_s) begin
        win_valid_r <= 1'b0;
      end
      if (win_hs_s) begin
        if (hcol_r == WC_LAST) begin
          hcol_r <= '0;
          hrow_r <= hrow_r + CNT_ONE;
        end else begin
          hcol_r <= hcol_r + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl with a multi-read-port bram model;
// expected windows are queued as their last pixel is accepted.
module tb_conv_window_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int W     = 7;
  localparam int H     = 7;
  localparam int K     = 3;
  localparam int DEPTH = K * W;
  localparam int PORTS = K * K;
  localparam int NPIX  = W * H;
  localparam int NWIN  = (H - K + 1) * (W - K + 1);

  logic                clk;
  logic                rstn, start, pix_valid, win_ready;
  logic [DW-1:0]       pix_data;
  logic                pix_ready, wr_en, win_valid, busy, frame_done;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       wr_data;
  logic [AW*PORTS-1:0] r_addrs;

  logic [DW-1:0]       mem [DEPTH];
  logic [DW*PORTS-1:0] bram_q;
  logic [DW-1:0]       img [NPIX];
  logic [DW*PORTS-1:0] exp_data_q [$];
  logic [AW*PORTS-1:0] exp_addr_q [$];

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  conv_window_ctrl #(
    .ADDR_WIDTH(AW), .RAM_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start),
    .i_pix_valid(pix_valid), .i_pix_data(pix_data), .o_pix_ready(pix_ready),
    .o_wr_en(wr_en), .o_w_addr(w_addr), .o_wr_data(wr_data), .o_r_addrs(r_addrs),
    .o_win_valid(win_valid), .i_win_ready(win_ready),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bram model: one write port, PORTS registered read ports
  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= wr_data;
    for (int p = 0; p < PORTS; p++) bram_q[p*DW +: DW] <= mem[r_addrs[p*AW +: AW]];
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel (row,col) lives at its raster index modulo the buffer depth.
  function automatic logic [AW*PORTS-1:0] win_addrs(input int r, input int c);
    logic [AW*PORTS-1:0] a = '0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        a[(ky*K+kx)*AW +: AW] = AW'(((r + ky) * W + c + kx) % DEPTH);
    return a;
  endfunction

  function automatic logic [DW*PORTS-1:0] win_data(input int r, input int c);
    logic [DW*PORTS-1:0] d = '0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        d[(ky*K+kx)*DW +: DW] = img[(r + ky) * W + c + kx];
    return d;
  endfunction

  // mode 0: full rate, 1: 5-cycle stall at window 0, 2: 1-cycle stall every window,
  // 3: random gaps plus stray start pulses. rst_at >= 0 aborts after that many windows.
  task automatic run_frame(input int mode, input int rst_at);
    int pix_idx = 0, win_cnt = 0, done_cnt = 0, cyc = 0, acc16 = -10, stall_left = 0;
    int r, c;
    bit first_seen = 0, cur_checked = 0, seen_done = 0, aborted = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    frame_no++;
    for (int i = 0; i < NPIX; i++) img[i] = DW'(i * 7 + frame_no * 50 + 3);
    exp_data_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b0; win_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && !aborted && cyc < 2000) begin
      pix_valid = (pix_idx < NPIX) && (mode != 3 || $urandom_range(0, 3) != 0);
      pix_data  = (pix_idx < NPIX) ? img[pix_idx] : '0;
      if (mode == 1 && win_valid && !first_seen) begin
        first_seen = 1;
        stall_left = 5;
      end
      case (mode)
        1:       win_ready = (stall_left == 0);
        2:       win_ready = !(win_valid && !cur_checked);
        3:       win_ready = ($urandom_range(0, 2) != 0);
        default: win_ready = 1'b1;
      endcase
      start = (mode == 3) && ($urandom_range(0, 4) == 0);
      #1;
      if (mode == 0 && cyc == acc16 + 1) check_val("first_raddr", 128'(r_addrs), 128'(win_addrs(0, 0)));
      if (mode == 0 && win_valid && !first_seen) begin
        first_seen = 1;
        check_val("first_valid_cycle", 128'(cyc), 128'(acc16 + 2));
      end
      if (stall_left > 0) begin
        check_val("stall_valid", 128'(win_valid), 128'(1'b1));
        check_val("stall_raddr", 128'(r_addrs), 128'(win_addrs(0, 0)));
        if (pix_idx >= 3 * W) check_val("stall_pix_ready", 128'(pix_ready), 128'(1'b0));
        stall_left--;
      end
      if (mode == 2 && win_valid && !win_ready) begin
        if (exp_addr_q.size() == 0) check_val("sb_underflow", 128'(0), 128'(1));
        else check_val("hold_raddr", 128'(r_addrs), 128'(exp_addr_q[0]));
        cur_checked = 1;
      end
      if (pix_valid && pix_ready) begin
        if (mode == 0) check_val("waddr", 128'(w_addr), 128'(pix_idx % DEPTH));
        if (pix_idx == 16) acc16 = cyc;
        r = pix_idx / W;
        c = pix_idx % W;
        if (r >= K - 1 && c >= K - 1) begin
          exp_data_q.push_back(win_data(r - K + 1, c - K + 1));
          exp_addr_q.push_back(win_addrs(r - K + 1, c - K + 1));
        end
        pix_idx++;
      end
      if (win_valid && win_ready) begin
        if (exp_data_q.size() == 0) begin
          check_val("sb_underflow", 128'(0), 128'(1));
        end else begin
          check_val("win_data", 128'(bram_q), 128'(exp_data_q[0]));
          exp_data_q.delete(0);
          exp_addr_q.delete(0);
        end
        win_cnt++;
        cur_checked = 0;
      end
      if (frame_done) begin
        done_cnt++;
        seen_done = 1;
      end
      if (rst_at >= 0 && win_cnt == rst_at) begin
        rstn = 1'b0;
        #1;
        check_val("rst_win_valid", 128'(win_valid), 128'(1'b0));
        check_val("rst_busy", 128'(busy), 128'(1'b0));
        check_val("rst_pix_ready", 128'(pix_ready), 128'(1'b0));
        pix_valid = 1'b0;
        win_ready = 1'b0;
        start     = 1'b0;
        aborted   = 1;
      end
      cyc++;
      if (!seen_done && !aborted) @(negedge clk);
    end
    if (!aborted) begin
      if (!seen_done) check_val("frame_timeout", 128'(0), 128'(1));
      start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        #1;
        if (frame_done) done_cnt++;
      end
      check_val("frame_done_cnt", 128'(done_cnt), 128'(1));
      check_val("win_cnt", 128'(win_cnt), 128'(NWIN));
      check_val("pix_cnt", 128'(pix_idx), 128'(NPIX));
      check_val("sb_empty", 128'(exp_data_q.size()), 128'(0));
      check_val("busy_idle", 128'(busy), 128'(1'b0));
      for (int i = 0; i < NPIX; i++) ref_mem[i % DEPTH] = img[i];
      for (int a = 0; a < DEPTH; a++) check_val("bram_contents", 128'(mem[a]), 128'(ref_mem[a]));
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_win_valid", 128'(win_valid), 128'(1'b0));
    check_val("reset_busy", 128'(busy), 128'(1'b0));
    check_val("reset_pix_ready", 128'(pix_ready), 128'(1'b0));
    check_val("reset_frame_done", 128'(frame_done), 128'(1'b0));
    check_val("reset_waddr", 128'(w_addr), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(0, 10);
    @(negedge clk);
    rstn = 1'b1;
    run_frame(0, -1);
    run_frame(3, -1);
    run_frame(3, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
